arm_pick_seq: RTL and testbench

Pick-and-place sequencer that sits directly upstream of the arm model. It drives the arm's Cartesian target (x, y), the inverse-solve enable, the forced-angle enable and the gripper request through one full pick → place → home cycle. The target is ramped in fixed Q16.16 steps so the inverse solver sees smooth motion. It is launched by a single start pulse carrying pick and place coordinates.

---
 rtl/arm_pkg.sv | 30 +++
 rtl/arm_pick_seq_axis_ramp.sv | 40 ++++
 rtl/arm_pick_seq.sv | 180 ++++++++++++++++++
 tb/tb_arm_pick_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared Q16.16 constants, sequencer state encoding and wait helper
// for the pick-and-place sequencer.
package arm_pkg;

  localparam int Q_W = 32;
  localparam logic [Q_W-1:0] Q_HALF = 32'h0000_8000;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_HOME         = 4'd1,
    S_MOVE_PICK    = 4'd2,
    S_SETTLE_PICK  = 4'd3,
    S_GRIP         = 4'd4,
    S_MOVE_PLACE   = 4'd5,
    S_SETTLE_PLACE = 4'd6,
    S_RELEASE      = 4'd7,
    S_RETURN       = 4'd8,
    S_DONE         = 4'd9
  } state_t;

  // A limit of 0 still leaves on the first tick.
  function automatic logic wait_done(
    input logic        tick,
    input logic [31:0] cnt,
    input logic [31:0] lim
  );
    return tick && ((cnt + 32'd1) >= lim);
  endfunction

endpackage

// File: rtl/arm_pick_seq_axis_ramp.sv
// Single-axis Q16.16 target stepper.
// ARM_PICK_SEQ_RAMP_EN selects bounded stepping; otherwise jump.
module axis_ramp
  import arm_pkg::*;
#(
  parameter logic [Q_W-1:0] STEP = Q_HALF
) (
  input  logic           i_tick,
  input  logic [Q_W-1:0] i_cur,
  input  logic [Q_W-1:0] i_tgt,
  output logic [Q_W-1:0] o_next,
  output logic           o_at_target
);

`ifdef ARM_PICK_SEQ_RAMP_EN
  logic [Q_W:0]   w_d;
  logic [Q_W:0]   w_mag;
  logic [Q_W-1:0] w_step;

  // 33-bit difference cannot overflow; msb is the sign.
  assign w_d   = {i_tgt[Q_W-1], i_tgt}
               - {i_cur[Q_W-1], i_cur};
  assign w_mag = w_d[Q_W] ? (~w_d + 33'd1) : w_d;

  assign w_step =
    (w_mag <= {1'b0, STEP}) ? i_tgt :
    (w_d[Q_W] ? (i_cur - STEP)
              : (i_cur + STEP));

  assign o_next = i_tick ? w_step : i_cur;
`else
  logic w_unused_step;

  assign w_unused_step = ^STEP;
  assign o_next = i_tick ? i_tgt : i_cur;
`endif

  assign o_at_target = (o_next == i_tgt);

endmodule

// File: rtl/arm_pick_seq.sv
// Pick -> place -> home sequencer driving the arm model target.
// ARM_PICK_SEQ_RAMP_EN (in axis_ramp) enables stepped motion.
module arm_pick_seq
  import arm_pkg::*;
#(
  parameter int unsigned     TICK_DIV     = 500_000,
  parameter logic [Q_W-1:0]  STEP         = Q_HALF,
  parameter int unsigned     SETTLE_TICKS = 50,
  parameter int unsigned     GRIP_TICKS   = 30,
  parameter logic [Q_W-1:0]  HOME_X       = 32'h0000_0000,
  parameter logic [Q_W-1:0]  HOME_Y       = 32'h0019_0000,
  parameter logic [Q_W-1:0]  HOME_XITA1   = 32'h005A_0000,
  parameter logic [Q_W-1:0]  HOME_XITA2   = 32'h005A_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Q_W-1:0] pick_x,
  input  logic [Q_W-1:0] pick_y,
  input  logic [Q_W-1:0] place_x,
  input  logic [Q_W-1:0] place_y,
  output logic [Q_W-1:0] x,
  output logic [Q_W-1:0] y,
  output logic           en1,
  output logic           en2,
  output logic [Q_W-1:0] set_xita1,
  output logic [Q_W-1:0] set_xita2,
  output logic           catch,
  output logic           busy,
  output logic           done
);

  localparam logic [31:0] L_TICK   = 32'(TICK_DIV - 1);
  localparam logic [31:0] L_SETTLE = 32'(SETTLE_TICKS);
  localparam logic [31:0] L_GRIP   = 32'(GRIP_TICKS);

  state_t         r_state, w_nstate;
  logic [31:0]    r_tick_cnt, r_wait, w_nwait;
  logic [Q_W-1:0] r_x, r_y, w_nx, w_ny;
  logic [Q_W-1:0] r_px, r_py, r_qx, r_qy;
  logic [Q_W-1:0] w_tx, w_ty, w_rx, w_ry;
  logic           w_tick, w_accept;
  logic           w_xat, w_yat;
  logic           r_en1, r_en2, r_catch;
  logic           r_busy, r_done;

  assign w_tick = (r_tick_cnt == L_TICK);

  always_ff @(posedge clk) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 32'd1;
  end

  assign w_tx = (r_state == S_MOVE_PLACE) ? r_qx : r_px;
  assign w_ty = (r_state == S_MOVE_PLACE) ? r_qy : r_py;

  axis_ramp #(.STEP(STEP)) u_ramp_x (
    .i_tick      (w_tick),
    .i_cur       (r_x),
    .i_tgt       (w_tx),
    .o_next      (w_rx),
    .o_at_target (w_xat)
  );

  axis_ramp #(.STEP(STEP)) u_ramp_y (
    .i_tick      (w_tick),
    .i_cur       (r_y),
    .i_tgt       (w_ty),
    .o_next      (w_ry),
    .o_at_target (w_yat)
  );

  always_comb begin
    w_nstate = r_state;
    w_nx     = r_x;
    w_ny     = r_y;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_accept = 1'b1;
        w_nx     = HOME_X;
        w_ny     = HOME_Y;
        w_nstate = S_HOME;
      end
      S_HOME:
        if (wait_done(w_tick, r_wait, L_SETTLE))
          w_nstate = S_MOVE_PICK;
      S_MOVE_PICK: if (w_tick) begin
        w_nx = w_rx;
        w_ny = w_ry;
        if (w_xat && w_yat) w_nstate = S_SETTLE_PICK;
      end
      S_SETTLE_PICK:
        if (wait_done(w_tick, r_wait, L_SETTLE))
          w_nstate = S_GRIP;
      S_GRIP:
        if (wait_done(w_tick, r_wait, L_GRIP))
          w_nstate = S_MOVE_PLACE;
      S_MOVE_PLACE: if (w_tick) begin
        w_nx = w_rx;
        w_ny = w_ry;
        if (w_xat && w_yat) w_nstate = S_SETTLE_PLACE;
      end
      S_SETTLE_PLACE:
        if (wait_done(w_tick, r_wait, L_SETTLE))
          w_nstate = S_RELEASE;
      S_RELEASE:
        if (wait_done(w_tick, r_wait, L_GRIP)) begin
          w_nstate = S_RETURN;
          w_nx     = HOME_X;
          w_ny     = HOME_Y;
        end
      S_RETURN:
        if (wait_done(w_tick, r_wait, L_SETTLE))
          w_nstate = S_DONE;
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    // Wait counter restarts on every state entry.
    if (w_nstate != r_state || r_state == S_IDLE)
      w_nwait = '0;
    else if (w_tick)
      w_nwait = r_wait + 32'd1;
    else
      w_nwait = r_wait;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_x     <= HOME_X;
      r_y     <= HOME_Y;
      r_en1   <= 1'b0;
      r_en2   <= 1'b0;
      r_catch <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_wait  <= w_nwait;
      r_x     <= w_nx;
      r_y     <= w_ny;
      r_en1   <= w_nstate inside {S_MOVE_PICK,
                 S_SETTLE_PICK, S_GRIP, S_MOVE_PLACE,
                 S_SETTLE_PLACE, S_RELEASE};
      r_en2   <= w_nstate inside {S_HOME, S_RETURN};
      r_catch <= w_nstate inside {S_GRIP,
                 S_MOVE_PLACE, S_SETTLE_PLACE};
      r_busy  <= (w_nstate != S_IDLE);
      r_done  <= (w_nstate == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px <= '0;
      r_py <= '0;
      r_qx <= '0;
      r_qy <= '0;
    end else if (w_accept) begin
      r_px <= pick_x;
      r_py <= pick_y;
      r_qx <= place_x;
      r_qy <= place_y;
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign en1       = r_en1;
  assign en2       = r_en2;
  assign catch     = r_catch;
  assign busy      = r_busy;
  assign done      = r_done;
  assign set_xita1 = HOME_XITA1;
  assign set_xita2 = HOME_XITA2;

endmodule

// File: tb/tb_arm_pick_seq.sv
// Directed bench for arm_pick_seq (TICK_DIV=4, SETTLE=2, GRIP=1).
// Expectations follow ARM_PICK_SEQ_RAMP_EN when it is defined.
module tb_arm_pick_seq;

  localparam logic [31:0] HY = 32'h0019_0000;
`ifdef ARM_PICK_SEQ_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pick_x = '0, pick_y = '0;
  logic [31:0] place_x = '0, place_y = '0;
  logic [31:0] x, y, set_xita1, set_xita2;
  logic        en1, en2, catch, busy, done;

  always #5 clk = ~clk;

  arm_pick_seq #(
    .TICK_DIV     (4),
    .STEP         (32'h0000_8000),
    .SETTLE_TICKS (2),
    .GRIP_TICKS   (1),
    .HOME_X       (32'h0000_0000),
    .HOME_Y       (HY),
    .HOME_XITA1   (32'h005A_0000),
    .HOME_XITA2   (32'h005A_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pick_x    (pick_x),
    .pick_y    (pick_y),
    .place_x   (place_x),
    .place_y   (place_y),
    .x         (x),
    .y         (y),
    .en1       (en1),
    .en2       (en2),
    .set_xita1 (set_xita1),
    .set_xita2 (set_xita2),
    .catch     (catch),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bench copy of the tick phase: 3 means the next edge ticks.
  int tb_cnt = 0;
  always @(posedge clk) begin
    if (rst)              tb_cnt <= 0;
    else if (tb_cnt == 3) tb_cnt <= 0;
    else                  tb_cnt <= tb_cnt + 1;
  end

  int          bcyc, hcyc, e2c, ysteps, dcnt;
  logic [31:0] xs[$];
  logic [31:0] fx, fy, lx, ly;
  logic        done_last, done_busy;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] px, py,
                        input logic [31:0] qx, qy);
    for (int i = 0; i < 8 && tb_cnt != 3; i++)
      step();
    pick_x  = px;
    pick_y  = py;
    place_x = qx;
    place_y = qy;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic run(input logic [31:0] px, py,
                     input logic [31:0] qx, qy,
                     input bit inj);
    bit          seen_en1, seen_catch;
    bit          released, injected;
    logic [31:0] last_x, last_y;
    launch(px, py, qx, qy);
    check("busy_rise", 32'(busy), 32'd1);
    check("en2_rise", 32'(en2), 32'd1);
    bcyc = 0; hcyc = 0; e2c = 0;
    ysteps = 0; dcnt = 0;
    xs.delete();
    fx = '0; fy = '0; lx = '0; ly = '0;
    done_last = 1'b0; done_busy = 1'b0;
    seen_en1 = 0; seen_catch = 0;
    released = 0; injected = 0;
    last_x = x;
    last_y = y;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      bcyc++;
      if (en2 && !seen_en1) hcyc++;
      if (en1) seen_en1 = 1;
      if (catch && !seen_catch) begin
        seen_catch = 1;
        fx = x;
        fy = y;
      end
      if (en1 && !seen_catch) begin
        e2c++;
        if (x != last_x) xs.push_back(x);
      end
      if (catch && y != last_y) ysteps++;
      if (seen_catch && !catch && !released) begin
        released = 1;
        lx = x;
        ly = y;
      end
      if (done) begin
        dcnt++;
        done_busy = busy;
      end
      done_last = done;
      if (inj && en1 && !injected) begin
        injected = 1;
        start    = 1'b1;
        pick_x   = 32'h0100_0000;
        pick_y   = 32'h0200_0000;
        place_x  = 32'h0300_0000;
        place_y  = 32'h0400_0000;
      end else begin
        start = 1'b0;
      end
      last_x = x;
      last_y = y;
      step();
    end
    start = 1'b0;
    check("run_ends", 32'(busy), 32'd0);
    check("done_once", 32'(dcnt), 32'd1);
    check("done_busy", 32'(done_busy), 32'd1);
    check("done_last", 32'(done_last), 32'd1);
  endtask

  task automatic check_main(input string tag);
    check({tag, "_home"}, 32'(hcyc), 32'd8);
    check({tag, "_xs_n"}, 32'(xs.size()),
          RAMP ? 32'd4 : 32'd1);
    check({tag, "_xs0"}, xs[0],
          RAMP ? 32'h0000_8000 : 32'h0002_0000);
    check({tag, "_xs_end"}, xs[$], 32'h0002_0000);
    check({tag, "_e2c"}, 32'(e2c),
          RAMP ? 32'd24 : 32'd12);
    check({tag, "_fx"}, fx, 32'h0002_0000);
    check({tag, "_fy"}, fy, HY);
    check({tag, "_ysteps"}, 32'(ysteps),
          RAMP ? 32'd10 : 32'd1);
    check({tag, "_lx"}, lx, 32'hFFFF_0000);
    check({tag, "_ly"}, ly, 32'h0014_0000);
    check({tag, "_busy"}, 32'(bcyc),
          RAMP ? 32'd97 : 32'd49);
    check({tag, "_x_home"}, x, 32'h0);
    check({tag, "_y_home"}, y, HY);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check("rst_x", x, 32'h0);
    check("rst_y", y, HY);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en1", 32'(en1), 32'd0);
    check("rst_en2", 32'(en2), 32'd0);
    check("rst_catch", 32'(catch), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("xita1", set_xita1, 32'h005A_0000);
    check("xita2", set_xita2, 32'h005A_0000);

    // pick (2.0, 25.0), place (-1.0, 20.0)
    run(32'h0002_0000, HY,
        32'hFFFF_0000, 32'h0014_0000, 1'b0);
    check_main("main");

    // odd distance 0.3 cm; zero-distance place move
    run(32'h0000_4CCC, HY,
        32'h0000_4CCC, HY, 1'b0);
    check("odd_xs_n", 32'(xs.size()), 32'd1);
    check("odd_xs0", xs[0], 32'h0000_4CCC);
    check("odd_e2c", 32'(e2c), 32'd12);
    check("odd_ysteps", 32'(ysteps), 32'd0);
    check("odd_lx", lx, 32'h0000_4CCC);
    check("odd_busy", 32'(bcyc), 32'd49);

    // start re-pulsed with new coordinates mid-move
    run(32'h0002_0000, HY,
        32'hFFFF_0000, 32'h0014_0000, 1'b1);
    check_main("inj");
    repeat (10) step();
    check("inj_idle", 32'(busy), 32'd0);

    // pick (10.0, 5.0): long ramp or single jump
    run(32'h000A_0000, 32'h0005_0000,
        32'h000A_0000, 32'h0005_0000, 1'b0);
    check("far_xs_n", 32'(xs.size()),
          RAMP ? 32'd20 : 32'd1);
    check("far_e2c", 32'(e2c),
          RAMP ? 32'd168 : 32'd12);
    check("far_fx", fx, 32'h000A_0000);
    check("far_fy", fy, 32'h0005_0000);
    check("far_busy", 32'(bcyc),
          RAMP ? 32'd205 : 32'd49);

    // reset during GRIP, with start high in the same cycle
    launch(32'h0002_0000, HY,
           32'hFFFF_0000, 32'h0014_0000);
    for (int i = 0; i < 200 && !catch; i++) step();
    check("grip_reached", 32'(catch), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    step();
    check("grst_catch", 32'(catch), 32'd0);
    check("grst_en1", 32'(en1), 32'd0);
    check("grst_en2", 32'(en2), 32'd0);
    check("grst_busy", 32'(busy), 32'd0);
    check("grst_x", x, 32'h0);
    check("grst_y", y, HY);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) step();
    check("grst_idle", 32'(busy), 32'd0);
    run(32'h0002_0000, HY,
        32'hFFFF_0000, 32'h0014_0000, 1'b0);
    check_main("again");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
